// File: rtl/note_player.sv
// Per-voice note control: fetches the phase step for a note from the frequency
// ROM, feeds the sine reader while the note lasts, and reports note expiry.
module note_player #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_to_load,
  input  logic [DUR_W-1:0]  duration_to_load,
  input  logic              beat,
  input  logic              generate_next_sample,
  input  logic [STEP_W-1:0] freq_step,
  output logic [NOTE_W-1:0] freq_addr,
  output logic [STEP_W-1:0] step_size,
  output logic              generate_next,
  output logic              done_with_note,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_PLAY} state_e;

  state_e              state_q;
  logic [NOTE_W-1:0]   note_q;
  logic [DUR_W-1:0]    dur_q;
  logic [STEP_W-1:0]   step_q;
  logic                done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      dur_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A load always restarts the fetch; the old step stays on the output
      // until the new ROM word arrives.
      if (load_new_note) begin
        note_q  <= note_to_load;
        dur_q   <= duration_to_load;
        state_q <= S_ADDR;
      end else begin
        case (state_q)
          S_ADDR: state_q <= S_DATA;
          S_DATA: begin
            if (dur_q == '0) begin
              state_q <= S_IDLE;
              step_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_PLAY;
              step_q  <= (note_q == '0) ? '0 : freq_step;
            end
          end
          S_PLAY: begin
            if (play_enable && beat && (dur_q != '0)) begin
              dur_q <= dur_q - 1'b1;
              if (dur_q == DUR_W'(1)) begin
                state_q <= S_IDLE;
                step_q  <= '0;
                done_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign freq_addr      = note_q;
  assign step_size      = step_q;
  assign done_with_note = done_q;
  assign busy           = (state_q != S_IDLE);
  assign generate_next  = generate_next_sample & play_enable & (state_q == S_PLAY);

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Per-voice control stage directly upstream of the sine sample reader.
- Accepts a note number and duration from the song sequencer and looks up the phase-increment in the external synchronous frequency ROM.
- Drives `step_size` and the `generate_next` strobe into the sine reader for the note's lifetime.
- Counts duration in beats and pulses `done_with_note` back to the sequencer.
- Note 0 is a rest: `step_size` is forced to 0.

Parameters:
- NOTE_W, 6, width of note number and ROM address.
- DUR_W, 6, width of duration field (beats).
- STEP_W, 20, width of phase step delivered to the sine reader.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- play_enable  in  1  1 = run, 0 = pause (hold everything).
- load_new_note  in  1  one-cycle request to start a note.
- note_to_load  in  NOTE_W  note number, 0 = rest.
- duration_to_load  in  DUR_W  note length in beats.
- beat  in  1  one-cycle beat tick from the tempo divider.
- generate_next_sample  in  1  sample-rate tick from the codec interface.
- freq_step  in  STEP_W  frequency ROM data; 1-cycle registered read latency.
- freq_addr  out  NOTE_W  frequency ROM address.
- step_size  out  STEP_W  phase increment to the sine reader.
- generate_next  out  1  advance strobe to the sine reader.
- done_with_note  out  1  one-cycle pulse when the note expires.
- busy  out  1  high in ADDR, DATA and PLAY.

Behaviour:
- Reset values (asynchronous): state IDLE, note_reg=0, dur_cnt=0, step_size=0, freq_addr=0, generate_next=0, done_with_note=0, busy=0.
- States: IDLE, ADDR, DATA, PLAY.
- `freq_addr` = note_reg at all times (registered value, no combinational path from `note_to_load`).

Load:
- `load_new_note`=1 in any state, regardless of `play_enable`, at edge t0:
  - note_reg<=note_to_load, dur_cnt<=duration_to_load, state<=ADDR.
  - `step_size` keeps its old value until t2.
- Load always restarts; an in-flight note is abandoned with no `done_with_note` pulse.

ADDR:
- Unconditionally -> DATA at t1. The ROM samples `freq_addr` at t1.

DATA, at t2:
- `step_size` <= (note_reg==0) ? 0 : freq_step.
- If dur_cnt==0 -> IDLE, `done_with_note` high for the cycle after t2, `step_size`<=0.
- Otherwise -> PLAY.

PLAY:
- On a cycle with `beat`=1, `play_enable`=1 and no load: dur_cnt<=dur_cnt-1.
- If dur_cnt==1 on that beat:
  - state<=IDLE, `step_size`<=0, `done_with_note` high exactly one cycle (registered, the cycle after the edge).
- `beat` in IDLE/ADDR/DATA: ignored, not banked.
- `play_enable`=0: dur_cnt, state and `step_size` frozen; ADDR/DATA still advance (ROM fetch completes).

Outputs:
- `generate_next` = generate_next_sample & play_enable & (state==PLAY). Combinational, zero latency.
- A rest plays for its duration with `step_size`=0 and `generate_next` still strobing.

Simultaneous events:
- `load_new_note` and expiring `beat` on the same edge: load wins, no done pulse.
- `load_new_note` during ADDR/DATA: fetch restarts from ADDR with the new note.

Other rules:
- Arithmetic: dur_cnt is unsigned DUR_W bits, never decremented below 0; no wrap.
- Reset mid-note: immediate return to reset values; the pending done pulse is lost.

Test Plan:
- Reset asserted mid-PLAY with step_size=0x01A2B -> all outputs 0 asynchronously, before the next clk edge; state IDLE.
- Load note=5, dur=3, ROM[5]=0x0ABCD -> freq_addr=5 after t0; step_size=0x0ABCD after t2; generate_next follows generate_next_sample; done_with_note pulses 1 cycle after the 3rd beat; step_size returns to 0.
- Load note=0 (rest), dur=2 -> step_size stays 0 while generate_next still strobes; done after 2 beats.
- Load dur=0, note=7 -> exactly one done_with_note pulse at t2+1; never enters PLAY; step_size=0 afterwards.
- play_enable=0 for 10 beats mid-note with dur_cnt=2 -> dur_cnt and step_size unchanged, generate_next=0; after re-enable, done after 2 more beats.
- Final beat coincides with load of note=9, dur=4 -> no done pulse; new fetch; step_size=ROM[9] two cycles later; done after 4 further beats.
